// File: rtl/csa_seq_adder_if.sv
// -----------------------------------------------------------------------------
// csa_seq_adder_if
// Operand/result bus for csa_seq_adder.
//   Operand side : in_valid, in_ready, a, b, ci (and sub when CSA_SEQ_SUB_EN
//                  is defined)
//   Result side  : out_valid, out_ready, sum, co
//   Status       : busy
// Modports:
//   master - operand producer / result consumer (drives operands and out_ready)
//   slave  - the adder itself
// Parameters N (chunk width) and K (chunk count) must match the adder's.
// -----------------------------------------------------------------------------
interface csa_seq_adder_if #(
   parameter int N = 3,
   parameter int K = 4
);
   localparam int W = N * K;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ci;
`ifdef CSA_SEQ_SUB_EN
   logic         sub;
`endif
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         co;
   logic         busy;

   modport master (
      output in_valid,
      input  in_ready,
      output a,
      output b,
      output ci,
`ifdef CSA_SEQ_SUB_EN
      output sub,
`endif
      input  out_valid,
      output out_ready,
      input  sum,
      input  co,
      input  busy
   );

   modport slave (
      input  in_valid,
      output in_ready,
      input  a,
      input  b,
      input  ci,
`ifdef CSA_SEQ_SUB_EN
      input  sub,
`endif
      output out_valid,
      input  out_ready,
      output sum,
      output co,
      output busy
   );
endinterface

// File: rtl/csa_seq_adder.sv
// -----------------------------------------------------------------------------
// csa_seq_adder
// Multi-cycle W = N*K bit adder. Operands are accepted over a valid/ready
// handshake, then pushed through a single N-bit carry-select adder one chunk
// per cycle, LSB chunk first, with the chunk carry-out fed back as the next
// chunk's carry-in. The result is held until the consumer accepts it.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - synchronous reset, active low
//   bus    - csa_seq_adder_if.slave:
//              in_valid/in_ready/a/b/ci[/sub]  operand handshake
//              out_valid/out_ready/sum/co      result handshake (registered)
//              busy                            high while computing or holding
//
// Optional feature macro: CSA_SEQ_SUB_EN
//   defined   - bus.sub selects subtraction (a - b, co=1 means no borrow)
//   undefined - add only, no sub signal
//
// Arithmetic: {co,sum} = a + b + ci (mod 2^(W+1)), unsigned.
// Latency: operands accepted on edge T -> out_valid high after edge T+K.
// -----------------------------------------------------------------------------

// N-bit carry-select adder: two ripple chains precomputed for carry-in 0 and
// carry-in 1, the real carry-in only picks between them.
module csa #(
   parameter int N = 3
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         ci,
   output logic [N-1:0] sum,
   output logic         co
);
   logic [N:0]   c0;
   logic [N:0]   c1;
   logic [N-1:0] s0;
   logic [N-1:0] s1;
   logic [N-1:0] p;
   logic [N-1:0] g;

   assign c0[0] = 1'b0;
   assign c1[0] = 1'b1;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi = gi + 1) begin : g_bit
         assign p[gi]      = a[gi] ^ b[gi];
         assign g[gi]      = a[gi] & b[gi];
         assign s0[gi]     = p[gi] ^ c0[gi];
         assign s1[gi]     = p[gi] ^ c1[gi];
         assign c0[gi + 1] = g[gi] | (p[gi] & c0[gi]);
         assign c1[gi + 1] = g[gi] | (p[gi] & c1[gi]);
      end
   endgenerate

   assign sum = ci ? s1 : s0;
   assign co  = ci ? c1[N] : c0[N];
endmodule

module csa_seq_adder #(
   parameter int N = 3,
   parameter int K = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   csa_seq_adder_if.slave    bus
);
   localparam int W  = N * K;
   localparam int IW = (K > 1) ? $clog2(K) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(K - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_reg, state_next;
   logic [IW-1:0] idx_reg, idx_next;
   logic          carry_reg, carry_next;
   logic [W-1:0]  a_reg, a_next;
   logic [W-1:0]  b_reg, b_next;
   logic [W-1:0]  sum_reg, sum_next;
   logic          co_reg, co_next;
   logic          out_valid_reg, out_valid_next;

   // Chunk datapath
   logic [N-1:0]  a_chunk [K];
   logic [N-1:0]  b_chunk [K];
   logic [N-1:0]  csa_a;
   logic [N-1:0]  csa_b;
   logic [N-1:0]  csa_sum;
   logic          csa_co;
   logic          run_active;

   assign run_active = (state_reg == S_RUN);

   genvar gi;
   generate
      for (gi = 0; gi < K; gi = gi + 1) begin : g_chunk
         assign a_chunk[gi] = a_reg[gi*N +: N];
         assign b_chunk[gi] = b_reg[gi*N +: N];
         // Only the chunk currently addressed by idx is overwritten; every
         // other chunk keeps its value, so sum holds the last result in IDLE.
         assign sum_next[gi*N +: N] = (run_active && (idx_reg == IW'(gi)))
                                      ? csa_sum : sum_reg[gi*N +: N];
      end
   endgenerate

   assign csa_a = a_chunk[idx_reg];
   assign csa_b = b_chunk[idx_reg];

   csa #(.N(N)) u_csa (
      .a   (csa_a),
      .b   (csa_b),
      .ci  (carry_reg),
      .sum (csa_sum),
      .co  (csa_co)
   );

   // Next-state / next-data logic
   always_comb begin
      state_next     = state_reg;
      idx_next       = idx_reg;
      carry_next     = carry_reg;
      a_next         = a_reg;
      b_next         = b_reg;
      co_next        = co_reg;
      out_valid_next = out_valid_reg;

      unique case (state_reg)
         S_IDLE: begin
            if (bus.in_valid) begin
               a_next = bus.a;
`ifdef CSA_SEQ_SUB_EN
               // a - b = a + ~b + 1; the caller's ci is irrelevant here.
               if (bus.sub) begin
                  b_next     = ~bus.b;
                  carry_next = 1'b1;
               end else begin
                  b_next     = bus.b;
                  carry_next = bus.ci;
               end
`else
               b_next     = bus.b;
               carry_next = bus.ci;
`endif
               idx_next   = '0;
               state_next = S_RUN;
            end
         end

         S_RUN: begin
            carry_next = csa_co;
            if (idx_reg == IDX_LAST) begin
               idx_next       = '0;
               co_next        = csa_co;
               out_valid_next = 1'b1;
               state_next     = S_DONE;
            end else begin
               idx_next = idx_reg + IW'(1);
            end
         end

         S_DONE: begin
            if (bus.out_ready) begin
               out_valid_next = 1'b0;
               state_next     = S_IDLE;
            end
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // State and data registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= S_IDLE;
         idx_reg       <= '0;
         carry_reg     <= 1'b0;
         a_reg         <= '0;
         b_reg         <= '0;
         sum_reg       <= '0;
         co_reg        <= 1'b0;
         out_valid_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         idx_reg       <= idx_next;
         carry_reg     <= carry_next;
         a_reg         <= a_next;
         b_reg         <= b_next;
         sum_reg       <= sum_next;
         co_reg        <= co_next;
         out_valid_reg <= out_valid_next;
      end
   end

   // in_ready is gated by rst_n so nothing looks acceptable during reset.
   assign bus.in_ready  = rst_n && (state_reg == S_IDLE);
   assign bus.busy      = (state_reg != S_IDLE);
   assign bus.out_valid = out_valid_reg;
   assign bus.sum       = sum_reg;
   assign bus.co        = co_reg;
endmodule

// File: tb/tb_csa_seq_adder.sv
// -----------------------------------------------------------------------------
// tb_csa_seq_adder
// Directed and random checks of csa_seq_adder with N=3, K=4 (W=12).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_csa_seq_adder;
   localparam int N = 3;
   localparam int K = 4;
   localparam int W = N * K;
   localparam int TIMEOUT = 40;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   csa_seq_adder_if #(.N(N), .K(K)) bus_if ();

   csa_seq_adder #(.N(N), .K(K)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one operand pair, then count falling edges until out_valid.
   // With hold=1, in_valid stays high and a/b/ci keep changing during RUN.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic sub, input bit hold,
                         output int lat);
      @(negedge clk);
      bus_if.in_valid = 1'b1;
      bus_if.a        = a;
      bus_if.b        = b;
      bus_if.ci       = ci;
`ifdef CSA_SEQ_SUB_EN
      bus_if.sub      = sub;
`else
      if (sub) $display("note: sub requested without CSA_SEQ_SUB_EN");
`endif
      @(negedge clk);
      lat = 0;
      while (bus_if.out_valid !== 1'b1 && lat < TIMEOUT) begin
         if (hold) begin
            bus_if.a  = W'($urandom);
            bus_if.b  = W'($urandom);
            bus_if.ci = ~bus_if.ci;
         end else begin
            bus_if.in_valid = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      if (!hold) bus_if.in_valid = 1'b0;
   endtask

   task automatic release_result();
      bus_if.out_ready = 1'b1;
      @(negedge clk);
      bus_if.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (bus_if.out_valid !== 1'b0) begin
         failures++; $display("FAIL reset_out_valid got %b want 0", bus_if.out_valid);
      end
      checks++;
      if (bus_if.sum !== 12'h000) begin
         failures++; $display("FAIL reset_sum got %h want 000", bus_if.sum);
      end
      checks++;
      if (bus_if.co !== 1'b0) begin
         failures++; $display("FAIL reset_co got %b want 0", bus_if.co);
      end
      checks++;
      if (bus_if.busy !== 1'b0) begin
         failures++; $display("FAIL reset_busy got %b want 0", bus_if.busy);
      end
      checks++;
      if (bus_if.in_ready !== 1'b0) begin
         failures++; $display("FAIL reset_in_ready got %b want 0", bus_if.in_ready);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (bus_if.in_ready !== 1'b1) begin
         failures++; $display("FAIL release_in_ready got %b want 1", bus_if.in_ready);
      end
      $display("reset: out_valid=%b sum=%h co=%b busy=%b in_ready=%b",
               bus_if.out_valid, bus_if.sum, bus_if.co, bus_if.busy, bus_if.in_ready);
   endtask

   task automatic test_add_wrap();
      int lat;
      run_op(12'hFFF, 12'h001, 1'b0, 1'b0, 1'b0, lat);
      $display("add FFF+001+0: lat=%0d sum=%h co=%b", lat, bus_if.sum, bus_if.co);
      checks++;
      if (lat !== K) begin
         failures++; $display("FAIL wrap_latency got %0d want %0d", lat, K);
      end
      checks++;
      if ({bus_if.co, bus_if.sum} !== 13'h1000) begin
         failures++; $display("FAIL wrap_result got co=%b sum=%h want co=1 sum=000",
                              bus_if.co, bus_if.sum);
      end
      checks++;
      if (bus_if.busy !== 1'b1 || bus_if.in_ready !== 1'b0) begin
         failures++; $display("FAIL wrap_done_flags got busy=%b in_ready=%b want 1/0",
                              bus_if.busy, bus_if.in_ready);
      end
      release_result();
      checks++;
      if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1 || bus_if.busy !== 1'b0) begin
         failures++; $display("FAIL wrap_idle got ov=%b in_ready=%b busy=%b want 0/1/0",
                              bus_if.out_valid, bus_if.in_ready, bus_if.busy);
      end
      checks++;
      if ({bus_if.co, bus_if.sum} !== 13'h1000) begin
         failures++; $display("FAIL wrap_idle_hold got co=%b sum=%h want co=1 sum=000",
                              bus_if.co, bus_if.sum);
      end
   endtask

   // Result is left in DONE for test_backpressure.
   task automatic test_hold_valid();
      int lat;
      run_op(12'h123, 12'h456, 1'b1, 1'b0, 1'b1, lat);
      $display("add 123+456+1 (in_valid held): lat=%0d sum=%h co=%b", lat, bus_if.sum, bus_if.co);
      checks++;
      if (lat !== K) begin
         failures++; $display("FAIL hold_latency got %0d want %0d", lat, K);
      end
      checks++;
      if ({bus_if.co, bus_if.sum} !== 13'h057A) begin
         failures++; $display("FAIL hold_result got co=%b sum=%h want co=0 sum=57A",
                              bus_if.co, bus_if.sum);
      end
      for (int i = 0; i < 3; i++) begin
         bus_if.a = W'($urandom);
         bus_if.b = W'($urandom);
         @(negedge clk);
         checks++;
         if ({bus_if.out_valid, bus_if.co, bus_if.sum} !== 14'h257A) begin
            failures++; $display("FAIL hold_done_ignore got ov=%b co=%b sum=%h want 1/0/57A",
                                 bus_if.out_valid, bus_if.co, bus_if.sum);
         end
      end
      bus_if.in_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if ({bus_if.out_valid, bus_if.co, bus_if.sum} !== 14'h257A) begin
            failures++; $display("FAIL bp_stable cycle %0d got ov=%b co=%b sum=%h want 1/0/57A",
                                 i, bus_if.out_valid, bus_if.co, bus_if.sum);
         end
      end
      release_result();
      $display("backpressure: 10 stalled cycles, after accept ov=%b in_ready=%b",
               bus_if.out_valid, bus_if.in_ready);
      checks++;
      if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1) begin
         failures++; $display("FAIL bp_release got ov=%b in_ready=%b want 0/1",
                              bus_if.out_valid, bus_if.in_ready);
      end
      checks++;
      if (bus_if.sum !== 12'h57A) begin
         failures++; $display("FAIL bp_idle_sum got %h want 57A", bus_if.sum);
      end
   endtask

   task automatic test_reset_mid_run();
      bit seen_valid;
      @(negedge clk);
      bus_if.in_valid = 1'b1;
      bus_if.a        = 12'h0AA;
      bus_if.b        = 12'h055;
      bus_if.ci       = 1'b0;
`ifdef CSA_SEQ_SUB_EN
      bus_if.sub      = 1'b0;
`endif
      @(negedge clk);            // accepted; first RUN cycle
      bus_if.in_valid = 1'b0;
      @(negedge clk);            // second RUN cycle
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      seen_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus_if.out_valid === 1'b1) seen_valid = 1'b1;
      end
      $display("reset mid-run: out_valid seen=%b busy=%b sum=%h", seen_valid, bus_if.busy, bus_if.sum);
      checks++;
      if (seen_valid !== 1'b0) begin
         failures++; $display("FAIL abort_out_valid got 1 want 0");
      end
      checks++;
      if (bus_if.busy !== 1'b0 || bus_if.in_ready !== 1'b1) begin
         failures++; $display("FAIL abort_idle got busy=%b in_ready=%b want 0/1",
                              bus_if.busy, bus_if.in_ready);
      end
      checks++;
      if (bus_if.sum !== 12'h000 || bus_if.co !== 1'b0) begin
         failures++; $display("FAIL abort_cleared got co=%b sum=%h want 0/000",
                              bus_if.co, bus_if.sum);
      end
   endtask

`ifdef CSA_SEQ_SUB_EN
   task automatic test_sub();
      int lat;
      run_op(12'd7, 12'd5, 1'b0, 1'b1, 1'b0, lat);
      $display("sub 7-5: lat=%0d sum=%h co=%b", lat, bus_if.sum, bus_if.co);
      checks++;
      if ({bus_if.co, bus_if.sum} !== 13'h1002 || lat !== K) begin
         failures++; $display("FAIL sub_7_5 got co=%b sum=%h lat=%0d want co=1 sum=002 lat=%0d",
                              bus_if.co, bus_if.sum, lat, K);
      end
      release_result();
      run_op(12'd5, 12'd7, 1'b1, 1'b1, 1'b0, lat);
      $display("sub 5-7: lat=%0d sum=%h co=%b", lat, bus_if.sum, bus_if.co);
      checks++;
      if ({bus_if.co, bus_if.sum} !== 13'h0FFE || lat !== K) begin
         failures++; $display("FAIL sub_5_7 got co=%b sum=%h lat=%0d want co=0 sum=FFE lat=%0d",
                              bus_if.co, bus_if.sum, lat, K);
      end
      release_result();
   endtask
`endif

   task automatic test_random();
      int          lat;
      logic [W-1:0] ra, rb;
      logic        rc, rs;
      logic [W:0]  exp_val;
      for (int t = 0; t < 1000; t++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         rs = 1'b0;
`ifdef CSA_SEQ_SUB_EN
         rs = 1'($urandom);
`endif
         if (rs) exp_val = {1'b0, ra} + {1'b0, ~rb} + (W+1)'(1);
         else    exp_val = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
         run_op(ra, rb, rc, rs, 1'b0, lat);
         $display("rand %0d: a=%h b=%h ci=%b sub=%b -> co=%b sum=%h exp=%h lat=%0d",
                  t, ra, rb, rc, rs, bus_if.co, bus_if.sum, exp_val, lat);
         checks++;
         if (lat !== K) begin
            failures++; $display("FAIL rand_latency #%0d got %0d want %0d", t, lat, K);
         end
         checks++;
         if ({bus_if.co, bus_if.sum} !== exp_val) begin
            failures++; $display("FAIL rand_result #%0d got %h want %h",
                                 t, {bus_if.co, bus_if.sum}, exp_val);
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
         release_result();
      end
   endtask

   initial begin
      checks           = 0;
      failures         = 0;
      rst_n            = 1'b0;
      bus_if.in_valid  = 1'b0;
      bus_if.a         = '0;
      bus_if.b         = '0;
      bus_if.ci        = 1'b0;
`ifdef CSA_SEQ_SUB_EN
      bus_if.sub       = 1'b0;
`endif
      bus_if.out_ready = 1'b0;

      test_reset();
      test_add_wrap();
      test_hold_valid();
      test_backpressure();
      test_reset_mid_run();
`ifdef CSA_SEQ_SUB_EN
      test_sub();
`endif
      test_random();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
